// File: rtl/matrix_stream_ctrl.sv
// matrix_stream_ctrl: streams A/B operands into a matrix accelerator, starts it, polls for completion and streams C back out.
// Load writes are registered, so LOAD_B holds one extra cycle for the final B write to drain before the START control write.
module matrix_stream_ctrl #(
  parameter int SIZE_ROW_MAX    = 8,
  parameter int SIZE_COLUMN_MAX = 4,
  parameter int TIMEOUT         = 4096
) (
  input  logic        CLOCK_25,
  input  logic        rst,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [7:0]  cfg_rows,
  input  logic [7:0]  cfg_cols,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic [31:0] m_data,
  output logic [12:0] m_address,
  output logic        m_we,
  input  logic [31:0] m_rdt,
  output logic        busy,
  output logic        err
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [7:0] RMAX = 8'(SIZE_ROW_MAX);
  localparam logic [7:0] KMAX = 8'(SIZE_COLUMN_MAX);
  typedef enum logic [3:0] {IDLE, LOAD_A, LOAD_B, START, POLL, CLEAR, RD_ADDR, RD_WAIT, OUT} state_t;
  state_t        state_q, state_d;
  logic [7:0]    r_q, r_d, k_q, k_d, in_lim, out_lim;
  logic [4:0]    a_q, a_d, b_q, b_d;
  logic [TW-1:0] t_q, t_d;
  logic          done_q, done_d, wr_q, wr_d, err_q, err_d;
  logic [12:0]   wa_q, wa_d;
  logic [31:0]   wd_q, wd_d, od_q, od_d;
  logic          in_hs, out_hs, a_end, b_end, cfg_ok;
  assign busy      = state_q != IDLE;
  assign cfg_ready = state_q == IDLE && !rst;
  assign in_ready  = (state_q == LOAD_A || state_q == LOAD_B) && !done_q;
  assign out_valid = state_q == OUT;
  assign out_last  = out_valid && a_end && b_end;
  assign out_data  = od_q;
  assign err       = err_q;
  assign in_hs     = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;
  // a_q walks the outer index (i, or k in LOAD_B), b_q the inner one
  assign in_lim    = state_q == LOAD_A ? k_q : r_q;
  assign out_lim   = state_q == LOAD_B ? k_q : r_q;
  assign b_end     = {3'd0, b_q} == in_lim - 8'd1;
  assign a_end     = {3'd0, a_q} == out_lim - 8'd1;
  assign cfg_ok    = cfg_rows != 8'd0 && cfg_rows <= RMAX && cfg_cols != 8'd0 && cfg_cols <= KMAX;
  assign m_we      = wr_q || state_q == START || state_q == CLEAR;
  assign m_address = wr_q ? wa_q : state_q == POLL ? 13'h1000 :
                     state_q == RD_ADDR ? {3'd3, a_q, b_q} : 13'd0;
  assign m_data    = wr_q ? wd_q : state_q == START ? {15'd0, 1'b1, r_q, k_q} :
                     state_q == CLEAR ? {16'd0, r_q, k_q} : 32'd0;
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    t_d     = t_q;
    done_d  = done_q;
    od_d    = od_q;
    err_d   = 1'b0;
    wr_d    = in_hs;
    wa_d    = {state_q == LOAD_A ? 3'd1 : 3'd2, a_q, b_q};
    wd_d    = in_data;
    if (in_hs || out_hs) begin
      b_d = b_end ? 5'd0 : b_q + 5'd1;
      a_d = !b_end ? a_q : a_end ? 5'd0 : a_q + 5'd1;
    end
    case (state_q)
      IDLE: if (cfg_valid) begin
        state_d = cfg_ok ? LOAD_A : IDLE;
        err_d   = !cfg_ok;
        r_d     = cfg_ok ? cfg_rows : r_q;
        k_d     = cfg_ok ? cfg_cols : k_q;
      end
      LOAD_A: state_d = in_hs && a_end && b_end ? LOAD_B : LOAD_A;
      LOAD_B: begin
        done_d  = done_q ? 1'b0 : in_hs && a_end && b_end;
        state_d = done_q ? START : LOAD_B;
      end
      START: begin
        t_d     = '0;
        state_d = POLL;
      end
      POLL: begin
        t_d = t_q + 1'b1;
        // the first POLL cycle still sees the read data of the START cycle
        if (t_q != '0 && m_rdt[0]) state_d = CLEAR;
        else if (t_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      CLEAR:   state_d = RD_ADDR;
      RD_ADDR: state_d = RD_WAIT;
      RD_WAIT: begin
        od_d    = m_rdt;
        state_d = OUT;
      end
      OUT:     if (out_hs) state_d = a_end && b_end ? IDLE : RD_ADDR;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLOCK_25) begin
    if (rst) begin
      state_q <= IDLE;
      r_q     <= '0;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      t_q     <= '0;
      done_q  <= 1'b0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      wa_q    <= '0;
      wd_q    <= '0;
      od_q    <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      t_q     <= t_d;
      done_q  <= done_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
      od_q    <= od_d;
    end
  end
endmodule

// File: tb/tb_matrix_stream_ctrl.sv
// tb_matrix_stream_ctrl: accelerator model plus table-driven and hand-written job sequences for matrix_stream_ctrl.
module tb_matrix_stream_ctrl;
  localparam int TO = 16;
  logic        clk = 1'b0, rst = 1'b1;
  logic        cfg_valid = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0]  cfg_rows = '0, cfg_cols = '0;
  logic [31:0] in_data = '0, m_rdt;
  logic        cfg_ready, in_ready, out_valid, out_last, m_we, busy, err;
  logic [31:0] out_data, m_data;
  logic [12:0] m_address;
  matrix_stream_ctrl #(.SIZE_ROW_MAX(8), .SIZE_COLUMN_MAX(4), .TIMEOUT(TO)) dut (
    .CLOCK_25(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_rows(cfg_rows), .cfg_cols(cfg_cols), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .m_data(m_data), .m_address(m_address), .m_we(m_we),
    .m_rdt(m_rdt), .busy(busy), .err(err)
  );
  always #5 clk = ~clk;
  // accelerator: memories, control register, finished flag after fin_delay cycles (0 = never)
  logic [31:0] am[32][32], bm[32][32], a_val[8][4], b_val[4][8];
  logic [31:0] ctrl = '0, start_w = '0, clr_w = '0;
  logic        fin = 1'b0;
  int          fcnt = 0, fin_delay = 10, n_we = 0, n_ld = 0, n_rd3 = 0;
  function automatic logic [31:0] acc_rd(input logic [12:0] a);
    logic [31:0] s;
    s = '0;
    case (a[12:10])
      3'd0: s = ctrl;
      3'd3: for (int kk = 0; kk < 32 && kk < int'(ctrl[7:0]); kk++) s += am[a[9:5]][kk] * bm[kk][a[4:0]];
      3'd4: s = {31'd0, fin};
      default: s = '0;
    endcase
    return s;
  endfunction
  always @(posedge clk) begin
    m_rdt <= acc_rd(m_address);
    if (m_we) n_we <= n_we + 1;
    if (!m_we && m_address[12:10] == 3'd3) n_rd3 <= n_rd3 + 1;
    if (m_we && m_address[12:10] == 3'd1) begin am[m_address[9:5]][m_address[4:0]] <= m_data; n_ld <= n_ld + 1; end
    if (m_we && m_address[12:10] == 3'd2) begin bm[m_address[9:5]][m_address[4:0]] <= m_data; n_ld <= n_ld + 1; end
    if (m_we && m_address == 13'd0) begin
      ctrl <= m_data;
      fin  <= 1'b0;
      fcnt <= m_data[16] ? fin_delay : 0;
      if (m_data[16]) start_w <= m_data; else clr_w <= m_data;
    end else if (fcnt > 0) begin
      fcnt <= fcnt - 1;
      if (fcnt == 1) fin <= 1'b1;
    end
  end
  int errors = 0, checks = 0;
  logic [31:0] res_q[$];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic logic [31:0] refc(input int i, input int j, input int k);
    logic [31:0] s;
    s = '0;
    for (int kk = 0; kk < k; kk++) s += a_val[i][kk] * b_val[kk][j];
    return s;
  endfunction
  task automatic fill(input int r, input int k);
    for (int i = 0; i < r; i++) for (int kk = 0; kk < k; kk++) a_val[i][kk] = $urandom_range(255);
    for (int kk = 0; kk < k; kk++) for (int j = 0; j < r; j++) b_val[kk][j] = $urandom_range(255);
  endtask
  task automatic cfg(input int r, input int k);
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_rows  = 8'(r);
    cfg_cols  = 8'(k);
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask
  task automatic feed(input int r, input int k, input int gap, input int lim, output int idx);
    logic [31:0] seq[$];
    int cyc;
    bit hs;
    for (int i = 0; i < r; i++) for (int kk = 0; kk < k; kk++) seq.push_back(a_val[i][kk]);
    for (int kk = 0; kk < k; kk++) for (int j = 0; j < r; j++) seq.push_back(b_val[kk][j]);
    idx = 0;
    cyc = 0;
    while (idx < seq.size() && idx < lim && cyc < 2000) begin
      in_valid = $urandom_range(99) >= gap;
      in_data  = seq[idx];
      hs = in_valid && in_ready;
      @(negedge clk);
      cyc++;
      if (hs) idx++;
    end
    in_valid = 1'b0;
  endtask
  task automatic run_job(input int r, input int k, input int fd, input int ig, input int og, input int stall_el);
    int w0, rd0, idx, got, nlast, cyc;
    bit hs, stalled;
    fin_delay = fd;
    w0 = n_ld;
    rd0 = n_rd3;
    stalled = 1'b0;
    res_q.delete();
    cfg(r, k);
    chk("busy_after_cfg", busy, 1);
    feed(r, k, ig, 1000, idx);
    chk("load_count", idx, 2 * r * k);
    got = 0;
    nlast = 0;
    cyc = 0;
    while (got < r * r && cyc < 5000) begin
      out_ready = $urandom_range(99) >= og;
      if (out_valid && got == stall_el && !stalled) begin
        stalled = 1'b1;
        out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          cyc++;
          chk("stall_valid", out_valid, 1);
          chk("stall_data", out_data, refc(got / r, got % r, k));
        end
        out_ready = 1'b1;
      end
      hs = out_valid && out_ready;
      if (hs) begin
        chk("c_data", out_data, refc(got / r, got % r, k));
        chk("c_last", out_last, got == r * r - 1);
        res_q.push_back(out_data);
        nlast += int'(out_last);
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    chk("out_count", got, r * r);
    chk("last_count", nlast, 1);
    chk("ld_writes", n_ld - w0, 2 * r * k);
    chk("rd3_reads", n_rd3 - rd0, r * r);
    chk("busy_end", busy, 0);
  endtask
  task automatic reject(input int r, input int k);
    int w;
    w = n_we;
    cfg(r, k);
    chk("rej_err", err, 1);
    chk("rej_cfg_ready", cfg_ready, 1);
    chk("rej_busy", busy, 0);
    @(negedge clk);
    chk("rej_err_pulse", err, 0);
    chk("rej_no_we", n_we - w, 0);
  endtask
  typedef struct {int r; int k; int fin; int ig; int og; bit bad;} vec_t;
  vec_t tbl[10];
  initial begin
    int idx, polls, cyc, w;
    logic [31:0] ctrl_prev;
    tbl[0] = '{1, 1, 3, 0, 0, 0};
    tbl[1] = '{2, 3, 5, 30, 30, 0};
    tbl[2] = '{0, 1, 5, 0, 0, 1};
    tbl[3] = '{3, 2, 1, 20, 0, 0};
    tbl[4] = '{2, 5, 5, 0, 0, 1};
    tbl[5] = '{8, 4, 10, 40, 40, 0};
    tbl[6] = '{9, 1, 5, 0, 0, 1};
    tbl[7] = '{4, 0, 5, 0, 0, 1};
    tbl[8] = '{8, 1, 2, 0, 50, 0};
    tbl[9] = '{1, 4, 14, 10, 10, 0};
    repeat (3) @(negedge clk);
    chk("rst_cfg_ready", cfg_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_we", m_we, 0);
    chk("rst_addr", m_address, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_cfg_ready", cfg_ready, 1);
    a_val[0][0] = 1; a_val[0][1] = 2; a_val[1][0] = 3; a_val[1][1] = 4;
    b_val[0][0] = 5; b_val[0][1] = 6; b_val[1][0] = 7; b_val[1][1] = 8;
    run_job(2, 2, 10, 0, 0, -1);
    chk("ex_start_word", start_w, 32'h10202);
    chk("ex_clear_word", clr_w, 32'h00202);
    chk("ex_c00", res_q.size() > 0 ? res_q[0] : 'x, 19);
    chk("ex_c01", res_q.size() > 1 ? res_q[1] : 'x, 22);
    chk("ex_c10", res_q.size() > 2 ? res_q[2] : 'x, 43);
    chk("ex_c11", res_q.size() > 3 ? res_q[3] : 'x, 50);
    for (int t = 0; t < 10; t++) begin
      if (tbl[t].bad) reject(tbl[t].r, tbl[t].k);
      else begin
        fill(tbl[t].r, tbl[t].k);
        run_job(tbl[t].r, tbl[t].k, tbl[t].fin, tbl[t].ig, tbl[t].og, -1);
      end
    end
    fill(2, 3);
    run_job(2, 3, 4, 0, 0, 1);
    fill(1, 1);
    fin_delay = 0;
    cfg(1, 1);
    feed(1, 1, 0, 1000, idx);
    polls = 0;
    cyc = 0;
    while (!err && cyc < 200) begin
      if (m_address == 13'h1000) polls++;
      @(negedge clk);
      cyc++;
    end
    chk("to_err_seen", err, 1);
    chk("to_polls", polls, TO);
    chk("to_busy", busy, 0);
    @(negedge clk);
    chk("to_err_pulse", err, 0);
    chk("to_cfg_ready", cfg_ready, 1);
    fill(2, 2);
    fin_delay = 10;
    cfg(2, 2);
    feed(2, 2, 0, 5, idx);
    chk("mid_feed", idx, 5);
    ctrl_prev = ctrl;
    in_valid = 1'b1;
    in_data  = 32'hdead;
    rst = 1'b1;
    @(negedge clk);
    w = n_we;
    in_valid = 1'b0;
    chk("mid_rst_we", m_we, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_cfg_ready", cfg_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_no_we", n_we - w, 0);
    chk("mid_rst_ctrl", ctrl, ctrl_prev);
    fill(1, 1);
    run_job(1, 1, 3, 0, 0, -1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
